// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants and state type for the imem loader
package imem_loader_pkg;

  localparam int          IMEM_DEPTH = 64;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_DRAIN,
    ST_RUN,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - fills imem with NOPs, streams a program in, then releases the core
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter  int DEPTH = IMEM_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          s_valid,
  input  logic [31:0]   s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_reset,
  output logic          busy,
  output logic          err,
  output logic [AW:0]   word_count
);

  localparam logic [AW:0] CLR_END = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_WC = (AW+1)'(DEPTH - 1);

  loader_state_t state;
  logic [AW:0]   clr;
  logic          handshake;

  assign s_ready   = (state == ST_LOAD);
  assign handshake = s_valid && s_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      clr        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_CLEAR;
            clr        <= '0;
            word_count <= '0;
            busy       <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // clr reaching DEPTH is the idle cycle between the last NOP write and LOAD
          if (clr == CLR_END) begin
            state <= ST_LOAD;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= clr[AW-1:0];
            wr_data <= NOP_INSTR;
            clr     <= clr + 1'b1;
          end
        end
        ST_LOAD: begin
          if (handshake) begin
            wr_en      <= 1'b1;
            wr_addr    <= word_count[AW-1:0];
            wr_data    <= s_data;
            word_count <= word_count + 1'b1;
            if (s_last) begin
              state <= ST_DRAIN;
            end else if (word_count == LAST_WC) begin
              state <= ST_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          state     <= ST_RUN;
          cpu_reset <= 1'b0;
          busy      <= 1'b0;
        end
        ST_RUN, ST_ERR: begin
          if (start) begin
            state      <= ST_CLEAR;
            clr        <= '0;
            word_count <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b1;
            err        <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized and table-driven bench for imem_loader
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = IMEM_DEPTH;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset, start, s_valid, s_last;
  logic [31:0]   s_data;
  logic          s_ready, wr_en, cpu_reset, busy, err;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   word_count;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_reset(cpu_reset), .busy(busy), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory as the core would see it, plus an ordered log of every committed write
  logic [AW+31:0] wlog[$];
  logic [31:0]    mem [DEPTH];
  always @(posedge clk) begin
    if (wr_en) begin
      wlog.push_back({wr_addr, wr_data});
      mem[wr_addr] <= wr_data;
    end
  end

  int checks = 0;
  int fails  = 0;
  int c0, hs_cyc;
  logic [31:0] prog [DEPTH];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    tick;
    start = 1'b1;
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_cpu_reset", cpu_reset, 1);
    chk("start_err_clear", err, 0);
    chk("start_word_count", word_count, 0);
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!s_ready && n < 200) begin
      tick;
      n++;
    end
    chk("ready_latency", cyc - c0, DEPTH + 1);
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input int gap);
    int n = 0;
    repeat (gap) tick;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 200) begin
      tick;
      n++;
    end
    if (n == 200) chk("handshake_timeout", s_ready, 1);
    tick;
    hs_cyc  = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic load_fixed_prog;
    prog[0] = 32'h00500113;
    prog[1] = 32'h00C00193;
    prog[2] = 32'h023103B3;
  endtask

  // Reference: every load is DEPTH NOP writes in address order, then program word i to address i
  task automatic check_load(input int n, input bit exp_err, input int max_gap);
    logic [AW+31:0] exp_q[$];
    logic [31:0]    expv;
    int bad  = 0;
    int badm = 0;
    if (exp_err) begin
      chk("err_flag", err, 1);
      chk("err_cpu_reset", cpu_reset, 1);
      chk("err_s_ready", s_ready, 0);
      chk("err_busy", busy, 0);
      s_valid = 1'b1;
      s_data  = 32'hDEADBEEF;
      s_last  = 1'b0;
      repeat (4) tick;
      chk("err_s_ready_hold", s_ready, 0);
      s_valid = 1'b0;
    end else begin
      chk("drain_cpu_reset", cpu_reset, 1);
      tick;
      chk("run_cpu_reset", cpu_reset, 0);
      chk("run_busy", busy, 0);
      chk("run_err", err, 0);
      if (max_gap == 0) chk("release_latency", cyc - c0, DEPTH + 2 + n);
      tick;
    end
    for (int a = 0; a < DEPTH; a++) exp_q.push_back({AW'(a), NOP_INSTR});
    for (int i = 0; i < n; i++) exp_q.push_back({AW'(i), prog[i]});
    chk("write_log_len", wlog.size(), exp_q.size());
    if (wlog.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) if (wlog[i] !== exp_q[i]) bad++;
    end
    chk("write_log_mismatches", bad, 0);
    chk("word_count", word_count, n);
    for (int k = 0; k < DEPTH; k++) begin
      expv = (k < n) ? prog[k] : NOP_INSTR;
      if (mem[k] !== expv) badm++;
    end
    chk("mem_mismatches", badm, 0);
  endtask

  typedef struct {
    int n;
    bit with_last;
    int max_gap;
    bit fixed;
    bit exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nl;
    vecs[0] = '{n: 3,  with_last: 1, max_gap: 0, fixed: 1, exp_err: 0};
    vecs[1] = '{n: 3,  with_last: 1, max_gap: 5, fixed: 1, exp_err: 0};
    vecs[2] = '{n: 1,  with_last: 1, max_gap: 0, fixed: 0, exp_err: 0};
    vecs[3] = '{n: 64, with_last: 0, max_gap: 0, fixed: 0, exp_err: 1};
    vecs[4] = '{n: 10, with_last: 1, max_gap: 3, fixed: 0, exp_err: 0};
    vecs[5] = '{n: 64, with_last: 1, max_gap: 0, fixed: 0, exp_err: 0};
    vecs[6] = '{n: 2,  with_last: 1, max_gap: 2, fixed: 0, exp_err: 0};

    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;

    for (int i = 0; i < 13; i++) begin
      if (i == 3) reset = 1'b0;
      tick;
      chk("reset_idle_outputs", {cpu_reset, s_ready, wr_en, busy, err}, 5'b10000);
    end

    foreach (vecs[v]) begin
      for (int j = 0; j < DEPTH; j++) prog[j] = $urandom;
      if (vecs[v].fixed) load_fixed_prog();
      wlog.delete();
      do_start();
      wait_ready();
      for (int j = 0; j < vecs[v].n; j++)
        send_word(prog[j], vecs[v].with_last && (j == vecs[v].n - 1),
                  $urandom_range(vecs[v].max_gap, 0));
      check_load(vecs[v].n, vecs[v].exp_err, vecs[v].max_gap);
    end

    // start pulsed in the middle of LOAD must not restart the sequence
    load_fixed_prog();
    wlog.delete();
    do_start();
    wait_ready();
    send_word(prog[0], 1'b0, 0);
    start = 1'b1;
    tick;
    tick;
    chk("ignore_start_busy", busy, 1);
    chk("ignore_start_s_ready", s_ready, 1);
    start = 1'b0;
    send_word(prog[1], 1'b0, 1);
    send_word(prog[2], 1'b1, 0);
    check_load(3, 1'b0, 1);

    // reset after two handshakes aborts to IDLE with no further writes
    wlog.delete();
    do_start();
    wait_ready();
    send_word($urandom, 1'b0, 0);
    send_word($urandom, 1'b0, 0);
    chk("pre_reset_word_count", word_count, 2);
    reset = 1'b1;
    #1;
    chk("midload_reset_busy", busy, 0);
    chk("midload_reset_word_count", word_count, 0);
    chk("midload_reset_cpu_reset", cpu_reset, 1);
    chk("midload_reset_wr_en", wr_en, 0);
    nl = wlog.size();
    s_valid = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    repeat (3) tick;
    chk("midload_idle_s_ready", s_ready, 0);
    chk("midload_idle_busy", busy, 0);
    chk("midload_no_writes", wlog.size(), nl);
    s_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
